countdown_ctrl: RTL and testbench
=================================

Name: countdown_ctrl

Overview:
- Two-digit BCD countdown sequencer.
- Owns the countdown value and drives the TimeH/TimeL digit inputs of the seven-segment display block.
- Takes load/start/pause pulses from the debounced key block and advances the count once per prescaled tick (1 Hz at the default divide).
- Flags completion with a one-cycle done pulse and a held alarm level.

Parameters:
TICK_DIV, 50000000, clock cycles per countdown tick (must be >= 2)
DIV_W, 26, prescaler counter width (2^DIV_W > TICK_DIV-1)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
load  input  1  one-cycle pulse: capture load_h/load_l
load_h  input  4  tens digit to load (BCD)
load_l  input  4  units digit to load (BCD)
start  input  1  one-cycle pulse: begin/resume counting
pause  input  1  one-cycle pulse: toggle pause while counting
TimeH  output  4  current tens digit (BCD), to display
TimeL  output  4  current units digit (BCD), to display
running  output  1  high while in RUN
done  output  1  one-cycle pulse on reaching 00
alarm  output  1  high while in DONE

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- All outputs are registered. Reset wins over every other input.
- Reset values: TimeH=0, TimeL=0, running=0, done=0, alarm=0, reload register=00, prescaler=0, state=IDLE.
- States: IDLE, RUN, PAUSE, DONE.
- Input priority within a cycle: load > start > pause.
- load, in any state:
  - Digits above 9 clamp to 9.
  - TimeH/TimeL and the reload register take the clamped values on the next edge.
  - Prescaler clears; state becomes IDLE.
- start:
  - IDLE: goes to RUN only if the count != 00; otherwise ignored and the state stays IDLE.
  - PAUSE: goes to RUN, with the prescaler resuming from its held value.
  - DONE: TimeH/TimeL reload from the reload register. If that value is 00, state goes to IDLE; otherwise RUN.
  - In every case that enters RUN from IDLE or DONE, the prescaler clears.
  - RUN: ignored.
- pause:
  - RUN: goes to PAUSE; prescaler and digits hold.
  - PAUSE: goes to RUN.
  - IDLE and DONE: ignored.
- running=1 exactly while in RUN. It rises on the edge after the accepted start.
- RUN operation:
  - Prescaler increments each cycle. At TICK_DIV-1 it wraps to 0 and a tick occurs in that cycle.
  - First decrement lands TICK_DIV cycles after running rises.
- Decrement on tick (BCD):
  - If TimeL != 0: TimeL-1.
  - Else: TimeL=9 and TimeH-1.
  - Digits never leave the range 0..9.
- Reaching 00:
  - On the tick whose result is 00, the next edge shows TimeH=0, TimeL=0, state=DONE, done=1 and alarm=1.
  - done drops after one cycle.
  - alarm holds until load, start or reset.
- A tick and a pause in the same cycle: the decrement is applied, then the state goes to PAUSE.
- A load in the same cycle as a tick: load wins and no decrement occurs.
- Reset mid-count: everything returns to reset values on the next edge, and no done pulse is produced.
- done is never asserted for a load of 00 or for a start ignored at 00.

Test Plan (TICK_DIV=4):
1. reset; load 2,5 -> TimeH=2, TimeL=5, running=0; start -> running=1 next cycle; 4 cycles later TimeH/TimeL=2,4; 4 cycles later 2,3.
2. load 1,0; start; one tick -> TimeH/TimeL=0,9 (borrow); continue -> 0,8 ... 0,1 -> 0,0 with done=1 for exactly 1 cycle, alarm=1 held, running=0.
3. load 0,3; start; after 2 cycles pause -> values hold at 0,3 for 20 cycles with running=0; pause again -> first decrement to 0,2 arrives 2 cycles later, not 4.
4. load 12,15 -> TimeH=9, TimeL=9; load 0,0 then start -> stays IDLE, running=0, done never asserted.
5. Count 0,2 to DONE; start -> TimeH/TimeL reload to 0,2, running=1, alarm=0; load 4,4 while running -> IDLE, TimeH/TimeL=4,4, prescaler cleared.
6. load 3,0; start; reset asserted mid-run -> next edge TimeH=0, TimeL=0, running=0, done=0, alarm=0; start with no load -> remains IDLE.

Source files
------------

// File: rtl/countdown_ctrl.sv
// rtl/countdown_ctrl.sv - two-digit BCD countdown sequencer with prescaled tick
module countdown_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int DIV_W    = 26
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_h,
    input  logic [3:0] load_l,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] TimeH,
    output logic [3:0] TimeL,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);

    state_t           state, state_n;
    logic [DIV_W-1:0] presc, presc_n;
    logic [3:0]       reload_h, reload_l, reload_h_n, reload_l_n;
    logic [3:0]       time_h_n, time_l_n;
    logic             done_n;
    logic             tick;
    logic [3:0]       dec_h, dec_l;
    logic             dec_zero;

    // Tick fires in the RUN cycle where the prescaler sits at its last value.
    always_comb begin
        tick = (state == RUN) && (presc == PRESC_LAST);
        if (TimeL != 4'd0) begin
            dec_h = TimeH;
            dec_l = TimeL - 4'd1;
        end else begin
            dec_h = (TimeH != 4'd0) ? TimeH - 4'd1 : 4'd0;
            dec_l = 4'd9;
        end
        dec_zero = (dec_h == 4'd0) && (dec_l == 4'd0);
    end

    // Next-state and next-data: load beats start beats pause; ticks act in RUN.
    always_comb begin
        state_n    = state;
        presc_n    = presc;
        reload_h_n = reload_h;
        reload_l_n = reload_l;
        time_h_n   = TimeH;
        time_l_n   = TimeL;
        done_n     = 1'b0;

        if (load) begin
            time_h_n   = (load_h > 4'd9) ? 4'd9 : load_h;
            time_l_n   = (load_l > 4'd9) ? 4'd9 : load_l;
            reload_h_n = time_h_n;
            reload_l_n = time_l_n;
            presc_n    = '0;
            state_n    = IDLE;
        end else if (start && (state != RUN)) begin
            case (state)
                IDLE: begin
                    if ((TimeH != 4'd0) || (TimeL != 4'd0)) begin
                        state_n = RUN;
                        presc_n = '0;
                    end
                end
                PAUSE: state_n = RUN;
                DONE: begin
                    time_h_n = reload_h;
                    time_l_n = reload_l;
                    presc_n  = '0;
                    state_n  = ((reload_h == 4'd0) && (reload_l == 4'd0)) ? IDLE : RUN;
                end
                default: state_n = state;
            endcase
        end else begin
            case (state)
                RUN: begin
                    if (tick) begin
                        presc_n  = '0;
                        time_h_n = dec_h;
                        time_l_n = dec_l;
                        if (dec_zero) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                        end else if (pause) begin
                            state_n = PAUSE;
                        end
                    end else if (pause) begin
                        state_n = PAUSE;
                    end else begin
                        presc_n = presc + DIV_W'(1);
                    end
                end
                PAUSE: begin
                    if (pause) begin
                        state_n = RUN;
                    end
                end
                default: state_n = state;
            endcase
        end
    end

    // State, counter and registered outputs; reset overrides everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            presc    <= '0;
            reload_h <= 4'd0;
            reload_l <= 4'd0;
            TimeH    <= 4'd0;
            TimeL    <= 4'd0;
            running  <= 1'b0;
            done     <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            state    <= state_n;
            presc    <= presc_n;
            reload_h <= reload_h_n;
            reload_l <= reload_l_n;
            TimeH    <= time_h_n;
            TimeL    <= time_l_n;
            running  <= (state_n == RUN);
            done     <= done_n;
            alarm    <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb/tb_countdown_ctrl.sv - directed self-checking bench for countdown_ctrl
module tb_countdown_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_h = 4'd0;
    logic [3:0] load_l = 4'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] TimeH, TimeL;
    logic       running, done, alarm;

    int checks = 0;
    int failures = 0;

    countdown_ctrl #(.TICK_DIV(4), .DIV_W(3)) dut (
        .clock(clock), .reset(reset), .load(load), .load_h(load_h), .load_l(load_l),
        .start(start), .pause(pause), .TimeH(TimeH), .TimeL(TimeL),
        .running(running), .done(done), .alarm(alarm)
    );

    always #5 clock = ~clock;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_load(input logic [3:0] h, input logic [3:0] l);
        load = 1'b1; load_h = h; load_l = l;
        step();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_pause();
        pause = 1'b1;
        step();
        pause = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        checks++; if ({TimeH, TimeL} !== 8'h00) begin failures++; $display("FAIL reset_time got %h want 00", {TimeH, TimeL}); end
        checks++; if ({running, done, alarm} !== 3'b000) begin failures++; $display("FAIL reset_flags got %b want 000", {running, done, alarm}); end
    endtask

    task automatic test_basic();
        do_load(4'd2, 4'd5);
        checks++; if ({TimeH, TimeL, running} !== {8'h25, 1'b0}) begin failures++; $display("FAIL load25 got %h r=%b want 25 r=0", {TimeH, TimeL}, running); end
        do_start();
        checks++; if (running !== 1'b1) begin failures++; $display("FAIL start_running got %b want 1", running); end
        step(3);
        checks++; if ({TimeH, TimeL} !== 8'h25) begin failures++; $display("FAIL pre_tick got %h want 25", {TimeH, TimeL}); end
        step();
        checks++; if ({TimeH, TimeL} !== 8'h24) begin failures++; $display("FAIL first_tick got %h want 24", {TimeH, TimeL}); end
        step(4);
        checks++; if ({TimeH, TimeL} !== 8'h23) begin failures++; $display("FAIL second_tick got %h want 23", {TimeH, TimeL}); end
    endtask

    task automatic test_borrow_done();
        do_load(4'd1, 4'd0);
        do_start();
        step(4);
        checks++; if ({TimeH, TimeL} !== 8'h09) begin failures++; $display("FAIL borrow got %h want 09", {TimeH, TimeL}); end
        for (int v = 8; v >= 1; v--) begin
            step(4);
            checks++; if ({TimeH, TimeL} !== {4'd0, 4'(v)} || done !== 1'b0) begin failures++; $display("FAIL count got %h d=%b want 0%0d d=0", {TimeH, TimeL}, done, v); end
        end
        step(4);
        checks++; if ({TimeH, TimeL, done, alarm, running} !== {8'h00, 3'b110}) begin failures++; $display("FAIL reach_zero got %h d=%b a=%b r=%b want 00 d=1 a=1 r=0", {TimeH, TimeL}, done, alarm, running); end
        step();
        checks++; if ({done, alarm, running} !== 3'b010) begin failures++; $display("FAIL done_pulse got d=%b a=%b r=%b want d=0 a=1 r=0", done, alarm, running); end
        step(5);
        checks++; if ({done, alarm, TimeH, TimeL} !== {2'b01, 8'h00}) begin failures++; $display("FAIL alarm_hold got d=%b a=%b t=%h want d=0 a=1 t=00", done, alarm, {TimeH, TimeL}); end
    endtask

    task automatic test_pause();
        do_load(4'd0, 4'd3);
        do_start();
        step(2);
        do_pause();
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL pause_running got %b want 0", running); end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++; if ({TimeH, TimeL, running} !== {8'h03, 1'b0}) begin failures++; $display("FAIL pause_hold cyc %0d got %h r=%b want 03 r=0", i, {TimeH, TimeL}, running); end
        end
        do_pause();
        checks++; if (running !== 1'b1) begin failures++; $display("FAIL resume_running got %b want 1", running); end
        step();
        checks++; if ({TimeH, TimeL} !== 8'h03) begin failures++; $display("FAIL resume_early got %h want 03", {TimeH, TimeL}); end
        step();
        checks++; if ({TimeH, TimeL} !== 8'h02) begin failures++; $display("FAIL resume_tick got %h want 02", {TimeH, TimeL}); end
    endtask

    task automatic test_clamp_zero();
        do_load(4'd12, 4'd15);
        checks++; if ({TimeH, TimeL} !== 8'h99) begin failures++; $display("FAIL clamp got %h want 99", {TimeH, TimeL}); end
        do_load(4'd0, 4'd0);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL load00_done got %b want 0", done); end
        do_start();
        for (int i = 0; i < 8; i++) begin
            checks++; if ({running, done, alarm, TimeH, TimeL} !== 11'd0) begin failures++; $display("FAIL start00 cyc %0d got r=%b d=%b a=%b t=%h want all 0", i, running, done, alarm, {TimeH, TimeL}); end
            step();
        end
    endtask

    task automatic test_restart_reload();
        do_load(4'd0, 4'd2);
        do_start();
        step(8);
        checks++; if ({TimeH, TimeL, done, alarm} !== {8'h00, 2'b11}) begin failures++; $display("FAIL to_done got %h d=%b a=%b want 00 d=1 a=1", {TimeH, TimeL}, done, alarm); end
        step();
        do_start();
        checks++; if ({TimeH, TimeL, running, alarm} !== {8'h02, 2'b10}) begin failures++; $display("FAIL restart got %h r=%b a=%b want 02 r=1 a=0", {TimeH, TimeL}, running, alarm); end
        step(2);
        do_load(4'd4, 4'd4);
        checks++; if ({TimeH, TimeL, running} !== {8'h44, 1'b0}) begin failures++; $display("FAIL load_running got %h r=%b want 44 r=0", {TimeH, TimeL}, running); end
        do_start();
        step(3);
        checks++; if ({TimeH, TimeL} !== 8'h44) begin failures++; $display("FAIL presc_cleared got %h want 44", {TimeH, TimeL}); end
        step();
        checks++; if ({TimeH, TimeL} !== 8'h43) begin failures++; $display("FAIL after_clear_tick got %h want 43", {TimeH, TimeL}); end
    endtask

    task automatic test_back_to_back();
        do_load(4'd0, 4'd5);
        do_start();
        step(3);
        do_pause();
        checks++; if ({TimeH, TimeL, running} !== {8'h04, 1'b0}) begin failures++; $display("FAIL tick_pause got %h r=%b want 04 r=0", {TimeH, TimeL}, running); end
        do_start();
        step(3);
        checks++; if ({TimeH, TimeL} !== 8'h04) begin failures++; $display("FAIL wrap_on_pause got %h want 04", {TimeH, TimeL}); end
        do_load(4'd7, 4'd7);
        checks++; if ({TimeH, TimeL, running, done} !== {8'h77, 2'b00}) begin failures++; $display("FAIL load_vs_tick got %h r=%b d=%b want 77 r=0 d=0", {TimeH, TimeL}, running, done); end
    endtask

    task automatic test_reset_midrun();
        do_load(4'd3, 4'd0);
        do_start();
        step(2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if ({TimeH, TimeL, running, done, alarm} !== 11'd0) begin failures++; $display("FAIL reset_mid got %h r=%b d=%b a=%b want all 0", {TimeH, TimeL}, running, done, alarm); end
        do_start();
        for (int i = 0; i < 6; i++) begin
            checks++; if ({TimeH, TimeL, running, done} !== 10'd0) begin failures++; $display("FAIL idle_after_reset cyc %0d got %h r=%b d=%b want all 0", i, {TimeH, TimeL}, running, done); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow_done();
        test_pause();
        test_clamp_zero();
        test_restart_reload();
        test_back_to_back();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
